csr_unit_m: RTL

Parametrised machine-mode CSR unit for the core. It replaces the single-interrupt CSR file with the following:
- three interrupt sources (external, timer, software) with standard priority
- synchronous exception entry
- mret return
- CSR write/set/clear operations
- 64-bit mcycle/minstret counters
- direct or vectored trap targets

It sits beside the decode/execute stage; the pipeline supplies pc and the retire/exception/mret strobes, and consumes trap_taken/trap_pc/mepc for redirection.

---
 rtl/csr_unit_m.sv | 285 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/csr_unit_m.sv
`default_nettype none
// ============================================================================
// Module      : csr_unit_m
// Description : Machine-mode CSR unit. Holds mstatus/mie/mtvec/mscratch/
//               mepc/mcause/mtval, exposes read-only mip/mhartid/misa, and
//               optional 64-bit mcycle/minstret counters. Decides traps
//               (exception beats interrupt; ext > soft > timer), handles
//               mret, and produces a registered one-cycle trap redirect.
// Ports       : clock/reset_n              clock, async active-low reset
//               csr_addr/csr_op/csr_w_data  CSR access (none/write/set/clear)
//               csr_r_data/csr_illegal      combinational read and legality
//               pc, retire                  current pc, retire strobe
//               irq_ext/irq_timer/irq_soft  level interrupt requests
//               exc_req/exc_cause/exc_tval  synchronous exception
//               mret                        return from trap
//               trap_taken/trap_pc          registered redirect pulse/target
//               mepc                        current return target
// Revision    : 1.0 - initial release
// ============================================================================
module csr_unit_m #(
  parameter int             XLEN        = 32,
  parameter logic [XLEN-1:0] MTVEC_RESET = 32'h000000F0,
  parameter int             COUNTER_EN  = 1,
  parameter logic [XLEN-1:0] HART_ID     = '0
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic [11:0]     csr_addr,
  input  logic [1:0]      csr_op,
  input  logic [XLEN-1:0] csr_w_data,
  output logic [XLEN-1:0] csr_r_data,
  output logic            csr_illegal,
  input  logic [XLEN-1:0] pc,
  input  logic            retire,
  input  logic            irq_ext,
  input  logic            irq_timer,
  input  logic            irq_soft,
  input  logic            exc_req,
  input  logic [3:0]      exc_cause,
  input  logic [XLEN-1:0] exc_tval,
  input  logic            mret,
  output logic            trap_taken,
  output logic [XLEN-1:0] trap_pc,
  output logic [XLEN-1:0] mepc
);

  localparam logic [11:0] c_MSTATUS   = 12'h300;
  localparam logic [11:0] c_MISA      = 12'h301;
  localparam logic [11:0] c_MIE       = 12'h304;
  localparam logic [11:0] c_MTVEC     = 12'h305;
  localparam logic [11:0] c_MSCRATCH  = 12'h340;
  localparam logic [11:0] c_MEPC      = 12'h341;
  localparam logic [11:0] c_MCAUSE    = 12'h342;
  localparam logic [11:0] c_MTVAL     = 12'h343;
  localparam logic [11:0] c_MIP       = 12'h344;
  localparam logic [11:0] c_MCYCLE    = 12'hB00;
  localparam logic [11:0] c_MINSTRET  = 12'hB02;
  localparam logic [11:0] c_MCYCLEH   = 12'hB80;
  localparam logic [11:0] c_MINSTRETH = 12'hB82;
  localparam logic [11:0] c_MHARTID   = 12'hF14;
  localparam logic [XLEN-1:0] c_MISA_VAL = 32'h40000100;
  localparam logic [XLEN-1:0] c_LOW2     = {{(XLEN-2){1'b1}}, 2'b00};

  // Architectural state. Interrupt-enable/pending vectors are packed as
  // [2]=external(bit 11), [1]=timer(bit 7), [0]=software(bit 3).
  logic            r_mstatus_mie;
  logic            r_mstatus_mpie;
  logic [2:0]      r_mie;
  logic [XLEN-1:0] r_mtvec;
  logic [XLEN-1:0] r_mscratch;
  logic [XLEN-1:0] r_mepc;
  logic [XLEN-1:0] r_mcause;
  logic [XLEN-1:0] r_mtval;
  logic [63:0]     r_mcycle;
  logic [63:0]     r_minstret;
  logic            r_trap_taken;
  logic [XLEN-1:0] r_trap_pc;

  logic [XLEN-1:0] w_rdata;
  logic            w_addr_ok;
  logic            w_read_only;
  logic            w_illegal;
  logic            w_we;
  logic [XLEN-1:0] w_wval;
  logic [2:0]      w_mip;
  logic [2:0]      w_pend;
  logic            w_irq;
  logic [3:0]      w_irq_code;
  logic            w_trap;
  logic [XLEN-1:0] w_base;
  logic [XLEN-1:0] w_trap_target;

  assign w_mip = {irq_ext, irq_timer, irq_soft};

  // Current-value read mux; also classifies the address.
  always_comb begin
    w_rdata     = '0;
    w_addr_ok   = 1'b0;
    w_read_only = 1'b0;
    case (csr_addr)
      c_MSTATUS: begin
        w_addr_ok     = 1'b1;
        w_rdata[12:11] = 2'b11;
        w_rdata[7]    = r_mstatus_mpie;
        w_rdata[3]    = r_mstatus_mie;
      end
      c_MISA: begin
        w_addr_ok = 1'b1;
        w_rdata   = c_MISA_VAL;
      end
      c_MIE: begin
        w_addr_ok   = 1'b1;
        w_rdata[11] = r_mie[2];
        w_rdata[7]  = r_mie[1];
        w_rdata[3]  = r_mie[0];
      end
      c_MTVEC:    begin w_addr_ok = 1'b1; w_rdata = r_mtvec;    end
      c_MSCRATCH: begin w_addr_ok = 1'b1; w_rdata = r_mscratch; end
      c_MEPC:     begin w_addr_ok = 1'b1; w_rdata = r_mepc;     end
      c_MCAUSE:   begin w_addr_ok = 1'b1; w_rdata = r_mcause;   end
      c_MTVAL:    begin w_addr_ok = 1'b1; w_rdata = r_mtval;    end
      c_MIP: begin
        w_addr_ok   = 1'b1;
        w_read_only = 1'b1;
        w_rdata[11] = w_mip[2];
        w_rdata[7]  = w_mip[1];
        w_rdata[3]  = w_mip[0];
      end
      c_MCYCLE: begin
        w_addr_ok = (COUNTER_EN != 0);
        w_rdata   = XLEN'(r_mcycle[31:0]);
      end
      c_MCYCLEH: begin
        w_addr_ok = (COUNTER_EN != 0);
        w_rdata   = XLEN'(r_mcycle[63:32]);
      end
      c_MINSTRET: begin
        w_addr_ok = (COUNTER_EN != 0);
        w_rdata   = XLEN'(r_minstret[31:0]);
      end
      c_MINSTRETH: begin
        w_addr_ok = (COUNTER_EN != 0);
        w_rdata   = XLEN'(r_minstret[63:32]);
      end
      c_MHARTID: begin
        w_addr_ok   = 1'b1;
        w_read_only = 1'b1;
        w_rdata     = HART_ID;
      end
      default: begin
        w_addr_ok = 1'b0;
      end
    endcase
  end

  assign w_illegal   = !w_addr_ok || (w_read_only && (csr_op != 2'b00));
  assign csr_illegal = w_illegal;
  assign csr_r_data  = w_illegal ? '0 : w_rdata;

  // Write/set/clear operate on the pre-update value.
  always_comb begin
    case (csr_op)
      2'b01:   w_wval = csr_w_data;
      2'b10:   w_wval = w_rdata | csr_w_data;
      2'b11:   w_wval = w_rdata & ~csr_w_data;
      default: w_wval = w_rdata;
    endcase
  end
  assign w_we = (csr_op != 2'b00) && !w_illegal;

  // Trap decision: any exception traps; interrupts need global MIE.
  assign w_pend = r_mie & w_mip;
  assign w_irq  = r_mstatus_mie && (w_pend != 3'b000) && !exc_req;
  always_comb begin
    if (w_pend[2])      w_irq_code = 4'd11;
    else if (w_pend[0]) w_irq_code = 4'd3;
    else                w_irq_code = 4'd7;
  end
  assign w_trap = exc_req || w_irq;

  assign w_base = r_mtvec & c_LOW2;
  assign w_trap_target = (r_mtvec[0] && w_irq)
                         ? (w_base + {{(XLEN-6){1'b0}}, w_irq_code, 2'b00})
                         : w_base;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_mstatus_mie  <= 1'b0;
      r_mstatus_mpie <= 1'b0;
      r_mie          <= 3'b000;
      r_mtvec        <= MTVEC_RESET & ~XLEN'(2);
      r_mscratch     <= '0;
      r_mepc         <= '0;
      r_mcause       <= '0;
      r_mtval        <= '0;
      r_trap_taken   <= 1'b0;
      r_trap_pc      <= '0;
    end else begin
      r_trap_taken <= w_trap;
      if (w_trap) begin
        r_trap_pc <= w_trap_target;
      end

      // Trap entry outranks mret, which outranks a software mstatus write.
      if (w_trap) begin
        r_mstatus_mpie <= r_mstatus_mie;
        r_mstatus_mie  <= 1'b0;
      end else if (mret) begin
        r_mstatus_mie  <= r_mstatus_mpie;
        r_mstatus_mpie <= 1'b1;
      end else if (w_we && (csr_addr == c_MSTATUS)) begin
        r_mstatus_mie  <= w_wval[3];
        r_mstatus_mpie <= w_wval[7];
      end

      if (w_trap) begin
        r_mepc <= pc & c_LOW2;
      end else if (w_we && (csr_addr == c_MEPC)) begin
        r_mepc <= w_wval & c_LOW2;
      end

      if (w_trap) begin
        r_mcause <= w_irq ? {1'b1, {(XLEN-5){1'b0}}, w_irq_code}
                          : {{(XLEN-4){1'b0}}, exc_cause};
      end else if (w_we && (csr_addr == c_MCAUSE)) begin
        r_mcause <= w_wval;
      end

      if (w_trap) begin
        r_mtval <= w_irq ? '0 : exc_tval;
      end else if (w_we && (csr_addr == c_MTVAL)) begin
        r_mtval <= w_wval;
      end

      // These commit even alongside a trap.
      if (w_we && (csr_addr == c_MIE)) begin
        r_mie <= {w_wval[11], w_wval[7], w_wval[3]};
      end
      if (w_we && (csr_addr == c_MTVEC)) begin
        r_mtvec <= w_wval & ~XLEN'(2);
      end
      if (w_we && (csr_addr == c_MSCRATCH)) begin
        r_mscratch <= w_wval;
      end
    end
  end

  generate
    if (COUNTER_EN != 0) begin : g_counters
      // A write to either half replaces it and suppresses that cycle's
      // increment, so no carry can leak into the other half.
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          r_mcycle   <= '0;
          r_minstret <= '0;
        end else begin
          if (w_we && (csr_addr == c_MCYCLE)) begin
            r_mcycle[31:0] <= w_wval[31:0];
          end else if (w_we && (csr_addr == c_MCYCLEH)) begin
            r_mcycle[63:32] <= w_wval[31:0];
          end else begin
            r_mcycle <= r_mcycle + 64'd1;
          end

          if (w_we && (csr_addr == c_MINSTRET)) begin
            r_minstret[31:0] <= w_wval[31:0];
          end else if (w_we && (csr_addr == c_MINSTRETH)) begin
            r_minstret[63:32] <= w_wval[31:0];
          end else if (retire) begin
            r_minstret <= r_minstret + 64'd1;
          end
        end
      end
    end else begin : g_no_counters
      assign r_mcycle   = '0;
      assign r_minstret = '0;
    end
  endgenerate

  assign trap_taken = r_trap_taken;
  assign trap_pc    = r_trap_pc;
  assign mepc       = r_mepc;

endmodule
`default_nettype wire
